// File: rtl/riscv_pkg.sv
// Shared opcode constants, reset instruction and fetch FSM encoding.
package riscv_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Only register-writing ALU forms are executed by the downstream datapath.
    function automatic logic is_supported(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response plus the fetch-to-datapath outputs.
interface instr_fetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instruction_o;
    logic        write_ena_o;
    logic [31:0] fetch_count_o;
    logic [15:0] illegal_count_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_rvalid_i, imem_rdata_i,
        output instruction_o, write_ena_o, fetch_count_o, illegal_count_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_rvalid_i, imem_rdata_i,
        input  instruction_o, write_ena_o, fetch_count_o, illegal_count_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry 32-bit FIFO buffering fetched instruction words.
// Latency: pushed word visible at head the cycle after the push.
// Backpressure: push ignored when full unless a pop frees the slot that cycle.
module fetch_fifo (
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] head,
    output logic [1:0]  count,
    output logic        empty,
    output logic        full
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, single-outstanding imem reads, 2-deep buffer, one instruction per pop.
// Latency: request one cycle after enable sampled in IDLE; instruction two cycles after rvalid.
// Backpressure: stall_i blocks pops only; fetching halts once the buffer holds two words.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          enable_i,
    input  logic          stall_i,
    instr_fetch_if.master bus
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         we_q;
    logic [31:0]  fetch_cnt_q;
    logic [15:0]  illegal_cnt_q;

    logic [31:0]  fifo_head;
    logic [1:0]   fifo_count;
    logic         fifo_empty;
    logic         fifo_full;
    logic         fifo_push;
    logic         fifo_pop;
    logic         imem_req;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        unique case (state_q)
            IDLE: if (enable_i && (fifo_count < 2'd2)) state_d = REQ;
            REQ: begin
                imem_req = 1'b1;
                state_d  = WAIT;
            end
            WAIT:    if (bus.imem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Responses outside WAIT belong to no outstanding request and are dropped.
    assign fifo_push = (state_q == WAIT) && bus.imem_rvalid_i;
    assign fifo_pop  = !stall_i && !fifo_empty;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            if (state_q == REQ) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            instr_q       <= NOP_INSTR;
            we_q          <= 1'b0;
            fetch_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else if (fifo_pop) begin
            instr_q     <= fifo_head;
            we_q        <= is_supported(fifo_head[6:0]);
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (!is_supported(fifo_head[6:0]) && (illegal_cnt_q != 16'hFFFF)) begin
                illegal_cnt_q <= illegal_cnt_q + 16'd1;
            end
        end else begin
            we_q <= 1'b0;
        end
    end

    fetch_fifo u_fifo (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (bus.imem_rdata_i),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // The IDLE entry check reserves a slot before each request is issued.
    a_no_overflow: assert property (@(posedge clock_i) disable iff (!resetb_i)
        fifo_push |-> !fifo_full);

    assign bus.imem_req_o      = imem_req;
    assign bus.imem_addr_o     = pc_q;
    assign bus.instruction_o   = instr_q;
    assign bus.write_ena_o     = we_q;
    assign bus.fetch_count_o   = fetch_cnt_q;
    assign bus.illegal_count_o = illegal_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC sequencing, opcode qualification, stall, late responses, reset, PC wrap.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic resetb;
    logic enable0;
    logic stall0;
    logic enable1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rsp_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] addr_log1[$];
    int          mem_lat = 1;
    int          rsp_cnt = 0;
    int          req_cnt = 0;
    int          req_base;

    instr_fetch_if bus0 ();
    instr_fetch_if bus1 ();

    instr_fetch #(.RESET_PC(32'h0000_0100)) dut0 (
        .clock_i  (clk),
        .resetb_i (resetb),
        .enable_i (enable0),
        .stall_i  (stall0),
        .bus      (bus0)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clock_i  (clk),
        .resetb_i (resetb),
        .enable_i (enable1),
        .stall_i  (1'b0),
        .bus      (bus1)
    );

    always #5 clk = ~clk;

    // Memory model for dut0: answers each request mem_lat cycles later with the next queued word.
    always @(negedge clk) begin
        bus0.imem_rvalid_i = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                bus0.imem_rvalid_i = 1'b1;
                if (rsp_q.size() > 0) bus0.imem_rdata_i = rsp_q.pop_front();
                else                  bus0.imem_rdata_i = 32'h0000_0013;
            end
        end
        if (bus0.imem_req_o === 1'b1) begin
            addr_log.push_back(bus0.imem_addr_o);
            req_cnt = req_cnt + 1;
            rsp_cnt = mem_lat;
        end
    end

    always @(negedge clk) begin
        if (bus1.imem_req_o === 1'b1) addr_log1.push_back(bus1.imem_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        resetb  = 1'b0;
        enable0 = 1'b0;
        stall0  = 1'b0;
        enable1 = 1'b0;
        bus0.imem_rvalid_i = 1'b0;
        bus0.imem_rdata_i  = '0;
        bus1.imem_rvalid_i = 1'b1;
        bus1.imem_rdata_i  = 32'h0000_0013;
        tick(3);

        check("rst_req",     bus0.imem_req_o,      32'd0);
        check("rst_addr",    bus0.imem_addr_o,     32'h0000_0100);
        check("rst_instr",   bus0.instruction_o,   32'h0000_0013);
        check("rst_we",      bus0.write_ena_o,     32'd0);
        check("rst_fetch",   bus0.fetch_count_o,   32'd0);
        check("rst_illegal", bus0.illegal_count_o, 32'd0);
        check("rst_addr1",   bus1.imem_addr_o,     32'hFFFF_FFF8);
        resetb = 1'b1;
        tick(1);

        // addi, add, jal with 1-cycle memory
        rsp_q.push_back(32'h0020_0093);
        rsp_q.push_back(32'h0020_80B3);
        rsp_q.push_back(32'h0000_006F);
        enable0 = 1'b1;
        tick(1);
        check("first_req",  bus0.imem_req_o,  32'd1);
        check("first_addr", bus0.imem_addr_o, 32'h0000_0100);
        tick(2);
        check("we_early", bus0.write_ena_o, 32'd0);
        tick(1);
        check("we_addi",    bus0.write_ena_o,   32'd1);
        check("instr_addi", bus0.instruction_o, 32'h0020_0093);
        check("fetch_1",    bus0.fetch_count_o, 32'd1);
        tick(3);
        check("we_add",     bus0.write_ena_o,     32'd1);
        check("instr_add",  bus0.instruction_o,   32'h0020_80B3);
        check("fetch_2",    bus0.fetch_count_o,   32'd2);
        check("illegal_0",  bus0.illegal_count_o, 32'd0);
        tick(1);
        enable0 = 1'b0;
        tick(2);
        check("instr_jal", bus0.instruction_o,   32'h0000_006F);
        check("we_jal",    bus0.write_ena_o,     32'd0);
        check("illegal_1", bus0.illegal_count_o, 32'd1);
        check("fetch_3",   bus0.fetch_count_o,   32'd3);
        check("addr_cnt",  addr_log.size(),      32'd3);
        check("addr_0", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'h0000_0100);
        check("addr_1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF, 32'h0000_0104);
        check("addr_2", (addr_log.size() > 2) ? addr_log[2] : 32'hDEAD_BEEF, 32'h0000_0108);

        // stall for 10 cycles: buffer fills with two words, then fetching stops
        tick(1);
        rsp_q.push_back(32'h0010_0113);
        rsp_q.push_back(32'h0031_0233);
        rsp_q.push_back(32'h0040_0193);
        req_base = req_cnt;
        stall0   = 1'b1;
        enable0  = 1'b1;
        tick(10);
        check("stall_req",   bus0.imem_req_o,      32'd0);
        check("stall_nreq",  req_cnt - req_base,   32'd2);
        check("stall_we",    bus0.write_ena_o,     32'd0);
        check("stall_instr", bus0.instruction_o,   32'h0000_006F);
        check("stall_fetch", bus0.fetch_count_o,   32'd3);
        stall0 = 1'b0;
        tick(1);
        check("rel_we0",    bus0.write_ena_o,   32'd1);
        check("rel_instr0", bus0.instruction_o, 32'h0010_0113);
        check("rel_req0",   bus0.imem_req_o,    32'd0);
        tick(1);
        check("rel_we1",    bus0.write_ena_o,   32'd1);
        check("rel_instr1", bus0.instruction_o, 32'h0031_0233);
        check("resume_req", bus0.imem_req_o,    32'd1);
        check("resume_addr", bus0.imem_addr_o,  32'h0000_0114);
        tick(1);
        enable0 = 1'b0;
        tick(2);
        check("resume_instr", bus0.instruction_o,   32'h0040_0193);
        check("resume_fetch", bus0.fetch_count_o,   32'd6);
        check("resume_ill",   bus0.illegal_count_o, 32'd1);

        // enable dropped while a 4-cycle read is outstanding
        tick(1);
        mem_lat  = 4;
        rsp_q.push_back(32'h0050_0293);
        req_base = req_cnt;
        enable0  = 1'b1;
        tick(1);
        check("slow_req",  bus0.imem_req_o,  32'd1);
        check("slow_addr", bus0.imem_addr_o, 32'h0000_0118);
        tick(1);
        enable0 = 1'b0;
        tick(5);
        check("slow_we",    bus0.write_ena_o,   32'd1);
        check("slow_instr", bus0.instruction_o, 32'h0050_0293);
        check("slow_fetch", bus0.fetch_count_o, 32'd7);
        tick(6);
        check("slow_nreq", req_cnt - req_base, 32'd1);

        // reset while waiting; the late response must be dropped
        rsp_q.push_back(32'h0060_0313);
        enable0 = 1'b1;
        tick(2);
        resetb  = 1'b0;
        enable0 = 1'b0;
        tick(1);
        check("mid_rst_req",     bus0.imem_req_o,      32'd0);
        check("mid_rst_addr",    bus0.imem_addr_o,     32'h0000_0100);
        check("mid_rst_instr",   bus0.instruction_o,   32'h0000_0013);
        check("mid_rst_we",      bus0.write_ena_o,     32'd0);
        check("mid_rst_fetch",   bus0.fetch_count_o,   32'd0);
        check("mid_rst_illegal", bus0.illegal_count_o, 32'd0);
        resetb = 1'b1;
        tick(6);
        check("late_fetch", bus0.fetch_count_o, 32'd0);
        check("late_instr", bus0.instruction_o, 32'h0000_0013);
        check("late_req",   bus0.imem_req_o,    32'd0);

        // PC wrap on dut1 with a zero-wait memory
        enable1 = 1'b1;
        tick(8);
        enable1 = 1'b0;
        tick(3);
        check("wrap_cnt", addr_log1.size(), 32'd3);
        check("wrap_0", (addr_log1.size() > 0) ? addr_log1[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check("wrap_1", (addr_log1.size() > 1) ? addr_log1[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_2", (addr_log1.size() > 2) ? addr_log1[2] : 32'hDEAD_BEEF, 32'h0000_0000);
        check("wrap_fetch", bus1.fetch_count_o, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the datapath top level. Keeps the program counter, issues single-outstanding reads to instruction memory and buffers returned words in a 2-entry FIFO. Presents one instruction per cycle on `instruction_o`, with `write_ena_o` qualifying the register-file write for supported opcodes (OP, OP-IMM). Keeps retired and illegal-instruction counters for debug.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset. Bits [1:0] are forced to 0.
- `clock_i` input 1: single clock, rising edge.
- `resetb_i` input 1: asynchronous, active-low reset.
- `enable_i` input 1: fetch enable. Sampled in IDLE only.
- `stall_i` input 1: downstream stall. While high, no FIFO pop and outputs hold.
- `imem_req_o` output 1: memory read request. Accepted in the same cycle it is high.
- `imem_addr_o` output 32: read address (current PC).
- `imem_rvalid_i` input 1: read data valid.
- `imem_rdata_i` input 32: read data.
- `instruction_o` output 32: instruction to the datapath.
- `write_ena_o` output 1: one-cycle strobe; the instruction is new and supported.
- `fetch_count_o` output 32: instructions delivered. Wraps.
- `illegal_count_o` output 16: unsupported opcodes delivered. Saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ when `enable_i`=1 and FIFO count < 2.
  - REQ → WAIT unconditionally.
  - WAIT → IDLE on `imem_rvalid_i`=1. Otherwise stay in WAIT.
- REQ issues a request: `imem_req_o`=1 and `imem_addr_o`=PC. PC advances by 4 on the same edge, wrapping 32'hFFFF_FFFC → 0. At most one request is outstanding.
- In WAIT, `imem_rvalid_i`=1 pushes `imem_rdata_i` into the FIFO. Room is guaranteed by the IDLE entry check.
- `imem_rvalid_i` in IDLE or REQ is ignored.
- Pop rule: when `stall_i`=0 and the FIFO is non-empty, the head is popped.
  - The popped word is registered into `instruction_o`.
  - `fetch_count_o` increments.
  - If opcode [6:0] is OP or OP-IMM, `write_ena_o`=1 for that cycle. Otherwise `write_ena_o`=0 and `illegal_count_o` increments (saturating).
- Cycles with no pop: `write_ena_o`=0 and `instruction_o` holds its last value.
- Simultaneous push and pop: FIFO count unchanged; the head is popped and the new word is written at the tail.
- `enable_i` dropping in WAIT does not cancel the outstanding read. The response is still pushed, then the FSM parks in IDLE.
- `stall_i` has no effect on the fetch FSM. It only blocks pops, and fetching halts naturally once the FIFO is full.

## Timing
- Reset values:
  - FSM=IDLE, PC=`RESET_PC`, FIFO empty.
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`.
  - `instruction_o`=32'h0000_0013 (NOP), `write_ena_o`=0, both counters=0.
- Reset mid-operation clears all state immediately. A response arriving after reset is ignored because the FSM is in IDLE.
- `enable_i` sampled high at cycle N (IDLE, FIFO not full): `imem_req_o`=1 at N+1.
- `imem_rvalid_i` at cycle M:
  - FIFO non-empty from M+1.
  - If `stall_i`=0 at M+1, `instruction_o` and `write_ena_o` are valid at M+2.
- Zero-wait memory (rvalid one cycle after req): one request every 3 cycles (REQ, WAIT, IDLE). Sustained rate is 1 instruction per 3 cycles.
- FIFO full (count=2): the FSM stays in IDLE and `imem_req_o` stays 0 until a pop occurs.

## Structure
- Shared package `riscv_pkg`:
  - `OPC_OP` = 7'b0110011
  - `OPC_OP_IMM` = 7'b0010011
  - `NOP_INSTR` = 32'h0000_0013
  - enum `fetch_state_t` {IDLE, REQ, WAIT}
- Sub-module `fetch_fifo`: 2-entry, 32-bit synchronous FIFO.
  - Ports: push, pop, data in, head out, count (2 bits), empty, full.
  - Same clock and reset as the parent.
- Parent contains the FSM, PC register, opcode check, output register and counters.

## Test plan
- Reset with `RESET_PC`=32'h100, raise `enable_i`, memory answers after 1 cycle → addresses 0x100, 0x104, 0x108 in order. First `write_ena_o` arrives 2 cycles after the first rvalid.
- Return 32'h0020_0093 (addi x1,x0,2) then 32'h0020_80B3 (add) → two `write_ena_o` pulses, `fetch_count_o`=2, `illegal_count_o`=0.
- Return 32'h0000_006F (jal) → `instruction_o`=32'h0000_006F, `write_ena_o`=0, `illegal_count_o`=1.
- Hold `stall_i`=1 for 10 cycles → exactly 2 words buffered, `imem_req_o` stays low. Release `stall_i` → both words delivered on consecutive cycles, then fetching resumes.
- Drop `enable_i` in WAIT with a 4-cycle memory latency → the response is still delivered and no further request is issued. Assert `resetb_i`=0 mid-WAIT → all outputs return to reset values and a late rvalid is ignored.
- `RESET_PC`=32'hFFFF_FFF8 → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
